instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch unit on the read side of the synchronous instruction memory. It owns the program counter and drives the memory's enable and address. It absorbs the memory's one-cycle read latency in a 2-entry buffer and hands instructions to decode over a valid/ready handshake. It also supports redirect (branch/jump) and fetch gating.

## Interface
Parameters:
- addWidth, 6, instruction address width; memory depth is 2**addWidth words.
- dataWidth, 16, instruction width.
- RESET_PC, 0, PC loaded on reset (addWidth bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_en  in  1  allows new memory reads when high; in-flight reads always complete.
- redirect  in  1  one-cycle pulse; flush and restart fetch at redirect_pc.
- redirect_pc  in  addWidth  new fetch address, sampled when redirect=1.
- mem_en  out  1  memory enable (read request), combinational from state.
- mem_addr  out  addWidth  memory address; equals pc register.
- mem_data  in  dataWidth  memory read data, valid the cycle after a request.
- out_valid  out  1  buffer head holds an instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  dataWidth  head instruction.
- out_pc  out  addWidth  address the head instruction was fetched from.

## Operation
- State: pc, buffer (2 entries of {instr, pc}), count (0..2), inflight flag + inflight_pc.
- pop = out_valid & out_ready; removes head at the clock edge.
- Issue condition (mem_en=1): !rst & !redirect & fetch_en & (count + inflight - pop < 2).
- On issue, pc <= pc+1 modulo 2**addWidth (63 wraps to 0 at default width), inflight <= 1, inflight_pc <= pc.
- Response: a cycle with inflight=1 writes {mem_data, inflight_pc} to the buffer tail at the clock edge. Push and pop in the same cycle are both honoured, and count is unchanged.
- Redirect (highest priority except rst): count <= 0 and inflight <= 0. The response arriving the next cycle is discarded. pc <= redirect_pc. No issue occurs in the redirect cycle. A pop in the same cycle is still accepted by decode; the flush happens after it.
- fetch_en low: no issue; the outstanding response still lands; the buffer drains normally.
- The buffer never overflows. A write when count=2 without a pop is a design error and must be asserted in simulation.
- out_instr and out_pc are don't-care when out_valid=0. Both are driven 0 after reset until the first push.
- The memory write port (we/di) is not driven by this block. It is tied off or owned by the loader.

## Timing
- Reset values: pc=RESET_PC, count=0, inflight=0, out_valid=0, out_instr=0, out_pc=0, mem_en=0 during rst.
- First issue occurs in the first cycle with rst=0 (cycle 0). out_valid=1 from cycle 2 with out_pc=RESET_PC.
- Redirect in cycle T: issue of redirect_pc in T+1, data in T+2, out_valid in T+3.
- Steady-state throughput is one instruction per cycle with out_ready held high.
- Stall: out_ready low means at most 2 buffered entries and no further issue. out_valid, out_instr and out_pc stay stable until accepted.
- On release of out_ready, the first pop happens in the same cycle and a new issue happens in that cycle.
- rst asserted mid-operation discards the buffer and inflight data on the next edge.

## Configuration
- Macro: FETCH_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It increments every cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and is cleared by rst. It is not cleared by redirect.
- Undefined: the port and counter are absent. Fetch behaviour is identical.

## Test plan
- Reset/cold start: memory preloaded word[i]=16'h1000+i, out_ready=1, rst released at cycle 0 -> out_valid from cycle 2, out_pc 0,1,2,… consecutive, out_instr 16'h1000,16'h1001,… with no bubbles.
- Wrap: RESET_PC=62 -> out_pc sequence 62,63,0,1 with matching instructions.
- Backpressure: out_ready low from cycle 4 for 5 cycles -> mem_en low after buffer fills. count peaks at 2. out_pc/out_instr are held. No instruction is lost or duplicated on release. With FETCH_STALL_CNT_EN, stall_cnt=5.
- Redirect: redirect=1, redirect_pc=20 in cycle 6 while streaming -> no instruction with out_pc 5..7 (wrong path) appears after cycle 6. The next out_valid is in cycle 9 with out_pc=20, out_instr=16'h1014.
- Redirect plus pop: redirect in a cycle with out_valid=out_ready=1 -> that head is accepted exactly once, then the flush applies.
- fetch_en gating and mid-run reset: fetch_en low for 3 cycles -> at most one more instruction lands, then out_valid drops after drain. rst for 1 cycle mid-stream -> out_valid=0 next cycle, and restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch unit on the read side of a synchronous instruction memory.
//   - Owns the program counter and drives the memory read enable and address.
//   - Absorbs the memory's one-cycle read latency in a 2-entry buffer.
//   - Hands instructions to decode over a valid/ready handshake.
//   - Supports redirect (branch/jump flush) and fetch gating (fetch_en).
//
// Optional feature macro: FETCH_STALL_CNT_EN
//   When defined, adds output stall_cnt[15:0]. It counts the cycles in which
//   the buffer head is valid but decode is not ready. The count saturates at
//   16'hFFFF. rst clears it and redirect does not.
//
// Parameters
//   addWidth   instruction address width (memory depth 2**addWidth words)
//   dataWidth  instruction width
//   RESET_PC   PC loaded on reset
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   fetch_en     in   allows new memory reads; in-flight reads always complete
//   redirect     in   one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch address, sampled when redirect=1
//   mem_en       out  memory read request (combinational)
//   mem_addr     out  memory address (the pc register)
//   mem_data     in   memory read data, valid the cycle after a request
//   out_valid    out  buffer head holds an instruction
//   out_ready    in   decode accepts the head this cycle
//   out_instr    out  head instruction
//   out_pc       out  address the head instruction was fetched from
//   stall_cnt    out  (FETCH_STALL_CNT_EN only) backpressure cycle counter
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                  addWidth  = 6,
  parameter int                  dataWidth = 16,
  parameter logic [addWidth-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect,
  input  logic [addWidth-1:0]  redirect_pc,
  output logic                 mem_en,
  output logic [addWidth-1:0]  mem_addr,
  input  logic [dataWidth-1:0] mem_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [dataWidth-1:0] out_instr,
  output logic [addWidth-1:0]  out_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // One buffered instruction together with the address it came from.
  typedef struct packed {
    logic [dataWidth-1:0] instr;
    logic [addWidth-1:0]  pc;
  } entry_t;

  localparam logic [addWidth-1:0] PC_ONE = addWidth'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [addWidth-1:0] pc_q,          pc_d;
  logic [1:0]          count_q,       count_d;
  logic                inflight_q,    inflight_d;
  logic [addWidth-1:0] inflight_pc_q, inflight_pc_d;
  entry_t              fifo_q [2];
  entry_t              fifo_d [2];

  // Control terms for the current cycle.
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] count_after_pop;

  // ---------------------------------------------------------------------------
  // Handshake and issue decision
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != 2'd0);
  assign out_instr = fifo_q[0].instr;
  assign out_pc    = fifo_q[0].pc;
  assign mem_addr  = pc_q;
  assign mem_en    = issue;

  always_comb begin
    pop  = out_valid & out_ready;
    // A read issued last cycle returns its data now.
    push = inflight_q;
    // Slots committed after this edge: buffered, plus the landing response,
    // minus the entry decode takes now. A new read is issued only when its
    // data is guaranteed a slot next cycle, so the buffer cannot overflow.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = !rst && !redirect && fetch_en && (occupancy < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave a value unassigned and no latch is inferred.
    pc_d          = pc_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fifo_d[0]     = fifo_q[0];
    fifo_d[1]     = fifo_q[1];

    // The head is always entry 0. On a pop the second entry shifts forward.
    if (pop) begin
      fifo_d[0] = fifo_q[1];
    end
    count_after_pop = count_q - {1'b0, pop};

    // The response goes into the first free slot after the pop. The
    // count_after_pop guard keeps an illegal overflow from overwriting the
    // head. The assertion below flags that case.
    if (push && (count_after_pop < 2'd2)) begin
      fifo_d[count_after_pop[0]] = '{instr: mem_data, pc: inflight_pc_q};
      count_d                    = count_after_pop + 2'd1;
    end else begin
      count_d = count_after_pop;
    end

    if (issue) begin
      pc_d          = pc_q + PC_ONE;  // wraps modulo 2**addWidth
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    // Redirect overrides the buffer and inflight updates. A pop in this cycle
    // has already been seen by decode. This response and the one arriving
    // next cycle are dropped, because count and inflight are cleared.
    if (redirect) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      pc_d       = redirect_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      // NOTE: the buffer storage is reset as well, so out_instr and out_pc
      // read 0 after reset until the first push.
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
      // A response into a full buffer with no pop would lose an instruction.
      if (!redirect) begin
        assert (!(push && (count_q == 2'd2) && !pop));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional backpressure statistics
  // ---------------------------------------------------------------------------
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A synchronous memory model
// holds word[i] = 16'h1000 + i. The main DUT is driven from a table of
// per-cycle vectors covering these cases:
//   - cold start
//   - backpressure
//   - mid-run reset
//   - redirect with a same-cycle pop
//   - fetch_en gating
// A second DUT with RESET_PC = 62 checks the PC wrap.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int AW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic          rst, fetch_en, redirect, out_ready;
  logic [AW-1:0] redirect_pc;
  logic          mem_en, out_valid;
  logic [AW-1:0] mem_addr, out_pc;
  logic [DW-1:0] mem_data, out_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  instruction_fetch #(.addWidth(AW), .dataWidth(DW), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- wrap DUT (RESET_PC = 62) ----------------
  logic          rst2;
  logic          mem_en2, out_valid2;
  logic [AW-1:0] mem_addr2, out_pc2;
  logic [DW-1:0] mem_data2, out_instr2;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]   stall_cnt2;
`endif

  instruction_fetch #(.addWidth(AW), .dataWidth(DW), .RESET_PC(6'd62)) dut2 (
    .clk(clk), .rst(rst2), .fetch_en(1'b1), .redirect(1'b0),
    .redirect_pc(6'd0), .mem_en(mem_en2), .mem_addr(mem_addr2),
    .mem_data(mem_data2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_instr(out_instr2), .out_pc(out_pc2)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  // ---------------- synchronous instruction memory ----------------
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = 16'h1000 + DW'(i);

  always @(posedge clk) begin
    if (mem_en)  mem_data  <= mem[mem_addr];
    if (mem_en2) mem_data2 <= mem[mem_addr2];
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          fe;
    logic          rd;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          exp_en;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] exp_instr;
    logic          chk_data;   // compare out_pc/out_instr this row
    logic          chk_stall;  // compare stall_cnt this row (macro builds)
    logic [15:0]   exp_stall;
  } vec_t;

  vec_t vecs[$];

  // The data fields are compared whenever out_valid is expected high. Rows
  // with valid low may still force a compare, for the post-reset zeros.
  function automatic void add(input logic r, input logic fe, input logic rd,
                              input logic [AW-1:0] rpc, input logic rdy,
                              input logic en, input logic v,
                              input logic [AW-1:0] pc, input logic [DW-1:0] instr,
                              input logic force_data, input logic cs,
                              input logic [15:0] st);
    vec_t e;
    e.rst = r; e.fe = fe; e.rd = rd; e.rpc = rpc; e.rdy = rdy;
    e.exp_en = en; e.exp_valid = v; e.exp_pc = pc; e.exp_instr = instr;
    e.chk_data = v | force_data; e.chk_stall = cs; e.exp_stall = st;
    vecs.push_back(e);
  endfunction

  logic [AW-1:0] wrap_pcs   [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
  logic [DW-1:0] wrap_instr [4] = '{16'h103E, 16'h103F, 16'h1000, 16'h1001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Row fields: rst fe rd rpc rdy | mem_en valid pc instr force_data chk_stall stall
    // Reset row: everything is zero.
    add(1, 1, 0, 0, 1,  0, 0, 0, 16'h0000, 1, 0, 0);
    // Cold start. Valid from cycle 2 with consecutive pcs.
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 1, 1, 0);   // c0: first issue
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c1
    add(0, 1, 0, 0, 1,  1, 1, 0, 16'h1000, 0, 0, 0);   // c2
    add(0, 1, 0, 0, 1,  1, 1, 1, 16'h1001, 0, 0, 0);   // c3
    // Backpressure: out_ready low in cycles 4..8. The buffer fills and the
    // head is held at pc 2.
    add(0, 1, 0, 0, 0,  0, 1, 2, 16'h1002, 0, 0, 0);   // c4
    for (int c = 5; c <= 8; c++)
      add(0, 1, 0, 0, 0, 0, 1, 2, 16'h1002, 0, 0, 0);
    // Release: pop and issue in the same cycle. Nothing is lost or repeated.
    add(0, 1, 0, 0, 1,  1, 1, 2, 16'h1002, 0, 1, 5);   // c9
    add(0, 1, 0, 0, 1,  1, 1, 3, 16'h1003, 0, 0, 0);   // c10
    add(0, 1, 0, 0, 1,  1, 1, 4, 16'h1004, 0, 0, 0);   // c11
    add(0, 1, 0, 0, 1,  1, 1, 5, 16'h1005, 0, 0, 0);   // c12
    // Mid-run reset: no issue during rst. The old head is still visible.
    add(1, 1, 0, 0, 1,  0, 1, 6, 16'h1006, 0, 0, 0);
    // Restart at RESET_PC with buffer and counter cleared.
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 1, 1, 0);   // c0
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c1
    add(0, 1, 0, 0, 1,  1, 1, 0, 16'h1000, 0, 0, 0);   // c2
    add(0, 1, 0, 0, 1,  1, 1, 1, 16'h1001, 0, 0, 0);   // c3
    add(0, 1, 0, 0, 1,  1, 1, 2, 16'h1002, 0, 0, 0);   // c4
    add(0, 1, 0, 0, 1,  1, 1, 3, 16'h1003, 0, 0, 0);   // c5
    // Redirect to 20 while pc 4 is popped. pc 4 is accepted once and the
    // wrong-path pcs 5..7 never appear.
    add(0, 1, 1, 20, 1, 0, 1, 4, 16'h1004, 0, 0, 0);   // c6
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c7: issue 20
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c8
    add(0, 1, 0, 0, 1,  1, 1, 20, 16'h1014, 0, 0, 0);  // c9: redirect target
    // fetch_en low for 3 cycles: one more response lands, then drain.
    add(0, 0, 0, 0, 1,  0, 1, 21, 16'h1015, 0, 0, 0);  // c10
    add(0, 0, 0, 0, 1,  0, 1, 22, 16'h1016, 0, 0, 0);  // c11
    add(0, 0, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 0);   // c12: drained
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c13: resume at 23
    add(0, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0);   // c14
    add(0, 1, 0, 0, 1,  1, 1, 23, 16'h1017, 0, 0, 0);  // c15

    rst = 1'b1; rst2 = 1'b1; fetch_en = 1'b1; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; fetch_en = vecs[i].fe; redirect = vecs[i].rd;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      #2;
      check($sformatf("row%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_en));
      check($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("row%0d_out_pc", i), 32'(out_pc), 32'(vecs[i].exp_pc));
        check($sformatf("row%0d_out_instr", i), 32'(out_instr), 32'(vecs[i].exp_instr));
      end
      if (vecs[i].rst == 1'b0 && vecs[i].exp_en)
        check($sformatf("row%0d_mem_addr_sane", i), 32'(mem_en & (mem_addr !== 'x)), 32'd1);
`ifdef FETCH_STALL_CNT_EN
      if (vecs[i].chk_stall)
        check($sformatf("row%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
`endif
      @(posedge clk);
      #1;
    end

    // Wrap sequence on the RESET_PC=62 instance. Expect 62,63,0,1 in cycles
    // 2..5 with no bubbles.
    rst = 1'b1;
    rst2 = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      #2;
      if (out_valid2) begin
        check($sformatf("wrap%0d_cycle", n), 32'(cyc), 32'(2 + n));
        check($sformatf("wrap%0d_out_pc", n), 32'(out_pc2), 32'(wrap_pcs[n]));
        check($sformatf("wrap%0d_out_instr", n), 32'(out_instr2), 32'(wrap_instr[n]));
        n++;
      end
      @(posedge clk);
      #1;
    end
    check("wrap_count", 32'(n), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
